// File: rtl/adc_sample_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_fifo_if
//  Description : Valid/ready sample stream from the ADC sample FIFO to the
//                OFDM receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_sample_fifo_if;
    logic [9:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input  m_ready);
    modport slave  (input  m_data, input  m_valid, output m_ready);
endinterface
`default_nettype wire

// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_fifo
//  Description : Captures completed mcp3002 conversions, acknowledges each one
//                with clear_available, optionally re-biases the sample to two's
//                complement and buffers it in a first-word fall-through FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_fifo #(
    parameter int DEPTH      = 16,
    parameter bit SIGNED_OUT = 1'b1
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   run,
    output logic                        adc_enable,
    input  wire logic [9:0]             adc_data,
    input  wire logic                   adc_available,
    output logic                        adc_clear_available,
    adc_sample_fifo_if.master           m_if,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    input  wire logic                   overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           enable_q, enable_d;
    logic           clear_q, clear_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [9:0]     mem_q [DEPTH];

    logic           take;
    logic           push;
    logic           pop;
    logic           empty;
    logic           full;
    logic [9:0]     wr_data_d;

    // Capture handshake: one capture per available pulse, clear held until available drops
    always_comb begin
        state_d = state_q;
        clear_d = clear_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (adc_available) begin
                    take    = 1'b1;
                    clear_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!adc_available) begin
                    clear_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    clear_d = 1'b1;
                end
            end
            default: begin
                clear_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !empty && m_if.m_ready;
        push       = take && run && (!full || pop);
        wr_ptr_d   = push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        enable_d   = run;
        wr_data_d  = SIGNED_OUT ? {~adc_data[9], adc_data[8:0]} : adc_data;
        // A drop in the same cycle as a clear request keeps the flag set
        if (take && run && !push) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state and pointers, all cleared at once by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b0;
            clear_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            clear_q    <= clear_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Sample storage; contents are meaningless outside the pointer window, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_d;
        end
    end

    assign adc_enable          = enable_q;
    assign adc_clear_available = clear_q;
    assign overflow            = overflow_q;
    assign level               = wr_ptr_q - rd_ptr_q;
    assign m_if.m_valid        = !empty;
    assign m_if.m_data         = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire
